mem_bus_arbiter: RTL and testbench

//  Two-port arbiter that shares the CPU's single-ported memory bus (MEM_ADDR/MEM_CS/MEM_WE/MEM_DATA)

---
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one single-ported memory bus between the instruction-fetch
//   requester (port I, read-only) and the load/store requester (port D).
//   One access at a time: IDLE (arbitrate) -> ACCESS (MEM_CS held for
//   MEM_LAT cycles) -> DONE (turnaround + one-cycle ACK) -> IDLE.
//   Round-robin on contention; the first tie after reset goes to port I.
//
// Parameters
//   AW       address width
//   DW       data width
//   MEM_LAT  cycles MEM_CS is held before read data is sampled (1..15)
//
// Ports
//   CLK, RST              clock (rising edge), asynchronous active-low reset
//   I_REQ/I_ADDR          fetch request, held until I_ACK
//   I_ACK/I_RDATA         one-cycle done pulse, fetch data (held until next fetch)
//   D_REQ/D_WE/D_ADDR/D_WDATA  load/store request, held until D_ACK
//   D_ACK/D_RDATA         one-cycle done pulse, load data (stores leave it alone)
//   MEM_ADDR/MEM_CS/MEM_WE memory control
//   MEM_DATA              shared tri-state data bus, driven only for stores
//   BUSY                  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          I_REQ,
  input  logic [AW-1:0] I_ADDR,
  output logic          I_ACK,
  output logic [DW-1:0] I_RDATA,
  input  logic          D_REQ,
  input  logic          D_WE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_ACK,
  output logic [DW-1:0] D_RDATA,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_CS,
  output logic          MEM_WE,
  inout  wire  [DW-1:0] MEM_DATA,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t        state, next_state;
  logic          grant;
  logic          grant_owner;
  logic          drive_en;

  logic          owner;
  logic          last_grant;
  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic [DW-1:0] lat_wdata;
  logic [3:0]    cnt;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, arbitration and bus control
  always_comb begin
    next_state  = state;
    grant       = 1'b0;
    grant_owner = OWN_I;
    MEM_CS      = 1'b0;
    MEM_WE      = 1'b0;
    drive_en    = 1'b0;
    I_ACK       = 1'b0;
    D_ACK       = 1'b0;
    BUSY        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (I_REQ && D_REQ) begin
          // Tie: whoever did not win last time goes now.
          grant       = 1'b1;
          grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (I_REQ) begin
          grant       = 1'b1;
          grant_owner = OWN_I;
        end else if (D_REQ) begin
          grant       = 1'b1;
          grant_owner = OWN_D;
        end
        if (grant) begin
          next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        MEM_CS   = 1'b1;
        MEM_WE   = lat_we;
        drive_en = lat_we;
        if (cnt == 4'd1) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        // Bus released for one turnaround cycle while the ACK pulses.
        I_ACK      = (owner == OWN_I);
        D_ACK      = (owner == OWN_D);
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Request latch, access counter and read-data capture
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owner      <= OWN_I;
      last_grant <= OWN_D;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      cnt        <= 4'd0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == S_IDLE && grant) begin
        // Everything the access needs is captured here, so requesters may
        // change or drop their inputs while the access runs.
        owner     <= grant_owner;
        lat_addr  <= (grant_owner == OWN_D) ? D_ADDR : I_ADDR;
        lat_we    <= (grant_owner == OWN_D) && D_WE;
        lat_wdata <= (grant_owner == OWN_D) ? D_WDATA : '0;
        cnt       <= 4'(MEM_LAT);
      end
      if (state == S_ACCESS) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1 && !lat_we) begin
          if (owner == OWN_D) begin
            d_rdata_q <= MEM_DATA;
          end else begin
            i_rdata_q <= MEM_DATA;
          end
        end
      end
      if (state == S_DONE) begin
        last_grant <= owner;
      end
    end
  end

  assign MEM_ADDR = lat_addr;
  assign MEM_DATA = drive_en ? lat_wdata : {DW{1'bz}};
  assign I_RDATA  = i_rdata_q;
  assign D_RDATA  = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Scoreboard bench for mem_bus_arbiter (MEM_LAT = 2). Expected accesses are
//   queued in grant order when stimulus is issued; a negedge monitor pops an
//   entry when MEM_CS rises and checks address, write data, CS length, ACK
//   routing and read data. A small memory model answers reads on the last
//   MEM_CS cycle only and otherwise holds the bus at zero, so any stray DUT
//   drive shows up as a corrupted bus value.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          I_ACK;
  logic [DW-1:0] I_RDATA;
  logic          D_REQ;
  logic          D_WE;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_ACK;
  logic [DW-1:0] D_RDATA;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_CS;
  logic          MEM_WE;
  wire  [DW-1:0] MEM_DATA;
  logic          BUSY;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_CS(MEM_CS), .MEM_WE(MEM_WE),
    .MEM_DATA(MEM_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          port;   // 0 = I, 1 = D
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t q[$];
  txn_t cur;

  int n_vec = 0;
  int n_err = 0;
  int cs_run = 0;
  int cyc = 0;
  int last_ack_cyc = -1;
  bit gap_chk = 0;
  bit data_valid = 0;
  logic [DW-1:0] exp_i = '0;
  logic [DW-1:0] exp_d = '0;

  logic          tb_en;
  logic [DW-1:0] tb_val;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory model: answers reads only on the sampling cycle, else drives 0.
  always_comb begin
    tb_en  = !(MEM_CS && MEM_WE);
    tb_val = '0;
    if (MEM_CS && !MEM_WE) begin
      tb_val = data_valid ? mem_val(MEM_ADDR) : 32'hBAD0_BAD0;
    end
  end
  assign MEM_DATA = tb_en ? tb_val : {DW{1'bz}};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic port, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
    txn_t t;
    t.port  = port;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = we ? '0 : mem_val(addr);
    return t;
  endfunction

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (!RST) begin
      cs_run     = 0;
      data_valid = 0;
    end else begin
      if (tb_en) chk("bus_undriven", MEM_DATA, tb_val);
      chk("one_ack", I_ACK & D_ACK, 0);
      if (MEM_CS) begin
        if (cs_run == 0) begin
          chk("q_empty_at_grant", q.size() == 0, 0);
          if (q.size() != 0) cur = q.pop_front();
        end
        cs_run++;
        chk("mem_addr", MEM_ADDR, cur.addr);
        chk("mem_we", MEM_WE, cur.we);
        if (cur.we) chk("mem_wdata", MEM_DATA, cur.wdata);
        chk("ack_in_access", {I_ACK, D_ACK}, 0);
        chk("busy_access", BUSY, 1);
        data_valid = (cs_run == LAT);
      end else if (cs_run != 0) begin
        chk("cs_len", cs_run, LAT);
        chk("i_ack", I_ACK, cur.port == 1'b0);
        chk("d_ack", D_ACK, cur.port == 1'b1);
        chk("busy_done", BUSY, 1);
        if (!cur.we) begin
          if (cur.port) exp_d = cur.rdata;
          else          exp_i = cur.rdata;
        end
        chk("i_rdata", I_RDATA, exp_i);
        chk("d_rdata", D_RDATA, exp_d);
        if (gap_chk && last_ack_cyc >= 0) chk("ack_period", cyc - last_ack_cyc, LAT + 2);
        last_ack_cyc = cyc;
        cs_run       = 0;
        data_valid   = 0;
      end else begin
        chk("no_ack_idle", {I_ACK, D_ACK}, 0);
        chk("busy_idle", BUSY, 0);
      end
    end
    cyc++;
  end

  task automatic drive_i(input logic [AW-1:0] addr);
    bit seen = 0;
    I_ADDR = addr;
    I_REQ  = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge CLK);
      if (I_ACK) seen = 1;
    end
    I_REQ = 1'b0;
    chk("i_ack_seen", seen, 1);
  endtask

  task automatic drive_d(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bit seen = 0;
    D_WE    = we;
    D_ADDR  = addr;
    D_WDATA = wdata;
    D_REQ   = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge CLK);
      if (D_ACK) seen = 1;
    end
    D_REQ = 1'b0;
    chk("d_ack_seen", seen, 1);
  endtask

  task automatic wait_cs();
    for (int k = 0; k < 20 && !MEM_CS; k++) @(negedge CLK);
    chk("cs_seen", MEM_CS, 1);
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    exp_i = '0;
    exp_d = '0;
    #1;
    chk("rst_cs", MEM_CS, 0);
    chk("rst_we", MEM_WE, 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_acks", {I_ACK, D_ACK}, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_bus", MEM_DATA, tb_val);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    chk("rst_i_rdata", I_RDATA, 0);
    chk("rst_d_rdata", D_RDATA, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    RST = 1'b0; I_REQ = 0; I_ADDR = '0; D_REQ = 0; D_WE = 0; D_ADDR = '0; D_WDATA = '0;
    @(negedge CLK);
    apply_reset();
    @(negedge CLK);

    // Single fetch from 0x10
    q.push_back(mk(1'b0, 1'b0, 32'h10, '0));
    drive_i(32'h10);
    @(negedge CLK);

    // Load so D_RDATA holds a known value, then a store that must not touch it
    q.push_back(mk(1'b1, 1'b0, 32'h44, '0));
    drive_d(1'b0, 32'h44, '0);
    q.push_back(mk(1'b1, 1'b1, 32'h40, 32'h1234_5678));
    drive_d(1'b1, 32'h40, 32'h1234_5678);
    chk("store_keeps_d_rdata", D_RDATA, mem_val(32'h44));
    @(negedge CLK);

    // Load with D_REQ dropped and inputs scrambled after one ACCESS cycle
    q.push_back(mk(1'b1, 1'b0, 32'h88, '0));
    D_WE = 1'b0; D_ADDR = 32'h88; D_REQ = 1'b1;
    wait_cs();
    @(negedge CLK);
    D_REQ = 1'b0; D_ADDR = 32'h0BAD; D_WE = 1'b1;
    begin
      bit seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge CLK);
        if (D_ACK) seen = 1;
      end
      chk("d_ack_after_drop", seen, 1);
    end
    D_WE = 1'b0;
    @(negedge CLK);

    // Simultaneous first request after reset: I then D
    apply_reset();
    q.push_back(mk(1'b0, 1'b0, 32'h100, '0));
    q.push_back(mk(1'b1, 1'b0, 32'h104, '0));
    fork
      drive_i(32'h100);
      drive_d(1'b0, 32'h104, '0);
    join

    // Both requesters held high: strict alternation at MEM_LAT+2 cycle spacing
    q.push_back(mk(1'b0, 1'b0, 32'h200, '0));
    q.push_back(mk(1'b1, 1'b1, 32'h300, 32'hA5A5_0001));
    q.push_back(mk(1'b0, 1'b0, 32'h204, '0));
    q.push_back(mk(1'b1, 1'b0, 32'h304, '0));
    q.push_back(mk(1'b0, 1'b0, 32'h208, '0));
    q.push_back(mk(1'b1, 1'b1, 32'h308, 32'hA5A5_0003));
    gap_chk      = 1;
    last_ack_cyc = -1;
    fork
      begin
        drive_i(32'h200);
        drive_i(32'h204);
        drive_i(32'h208);
      end
      begin
        drive_d(1'b1, 32'h300, 32'hA5A5_0001);
        drive_d(1'b0, 32'h304, '0);
        drive_d(1'b1, 32'h308, 32'hA5A5_0003);
      end
    join
    gap_chk = 0;
    @(negedge CLK);

    // Reset during the second ACCESS cycle of a fetch: bus released at once, no ACK
    q.push_back(mk(1'b0, 1'b0, 32'h20, '0));
    I_ADDR = 32'h20; I_REQ = 1'b1;
    wait_cs();
    @(negedge CLK);
    #2;
    RST = 1'b0; I_REQ = 1'b0;
    exp_i = '0; exp_d = '0;
    #1;
    chk("midrst_cs", MEM_CS, 0);
    chk("midrst_we", MEM_WE, 0);
    chk("midrst_bus", MEM_DATA, tb_val);
    chk("midrst_acks", {I_ACK, D_ACK}, 0);
    chk("midrst_busy", BUSY, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_i_rdata", I_RDATA, 0);

    chk("q_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
